// File: rtl/bank4way16_scan_if.sv
// Bus bundle between the slot-bank scan engine and its upstream writer / downstream consumer.
// The master modport is the environment side; the slave modport is the scan engine.
interface bank4way16_scan_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PCNT_W = 8
);
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              start;
    logic              loop;
    logic [3:0]        slot_en;
    logic              stop;
    logic              out_ready;
    logic [WIDTH-1:0]  slot_a;
    logic [WIDTH-1:0]  slot_b;
    logic [WIDTH-1:0]  slot_c;
    logic [WIDTH-1:0]  slot_d;
    logic [1:0]        sel;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] pass_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, start, loop, slot_en, stop, out_ready,
        input  slot_a, slot_b, slot_c, slot_d, sel, out_valid, busy, done, pass_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, loop, slot_en, stop, out_ready,
        output slot_a, slot_b, slot_c, slot_d, sel, out_valid, busy, done, pass_cnt
    );
endinterface

// File: rtl/bank4way16_scan.sv
// Four-slot register bank feeding a 4:1 mux, with a handshaked scan engine that walks the
// enabled slots once per pass (single-pass or continuous).
module bank4way16_scan #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] SLOT_RST = '0,
    parameter int unsigned      PCNT_W   = 8
) (
    input logic               clk,
    input logic               reset,
    bank4way16_scan_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [3:0]        mask_q, mask_d;
    logic              loop_q, loop_d;
    logic [1:0]        sel_q, sel_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]  slot_q [4];

    logic              xfer;
    logic              nxt_found;
    logic [1:0]        nxt_idx;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Lowest set bit strictly above cur; found=0 means cur is the last slot of the pass.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && m[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign xfer                 = valid_q && bus.out_ready;
    assign {nxt_found, nxt_idx} = next_above(mask_q, sel_q);

    // State register plus all registered datapath/outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mask_q  <= 4'b0000;
            loop_q  <= 1'b0;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pcnt_q  <= '0;
            for (int i = 0; i < 4; i++) slot_q[i] <= SLOT_RST;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            loop_q  <= loop_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
            if (bus.wr_en) slot_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop && bus.slot_en != 4'b0000) state_d = StScan;
            end
            StScan: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (xfer && !nxt_found && !loop_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        loop_d  = loop_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    if (bus.slot_en != 4'b0000) begin
                        mask_d  = bus.slot_en;
                        loop_d  = bus.loop;
                        sel_d   = lowest_set(bus.slot_en);
                        valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StScan: begin
                // stop takes priority over any transfer in the same cycle.
                if (bus.stop) begin
                    valid_d = 1'b0;
                end else if (xfer) begin
                    if (nxt_found) begin
                        sel_d = nxt_idx;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                        if (loop_q) begin
                            sel_d = lowest_set(mask_q);
                        end else begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign bus.slot_a    = slot_q[0];
    assign bus.slot_b    = slot_q[1];
    assign bus.slot_c    = slot_q[2];
    assign bus.slot_d    = slot_q[3];
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == StScan);
    assign bus.done      = done_q;
    assign bus.pass_cnt  = pcnt_q;

endmodule
